// File: rtl/wave_capture.sv
// Capture side of the waveform RAM: arms on a positive-going zero crossing,
// fills the undisplayed half with 256 offset-binary samples, then hands it over.
module wave_capture #(
  parameter int unsigned DECIM    = 1,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEC_W = 8;
  localparam logic [DEC_W-1:0] DEC_RELOAD = DEC_W'(DECIM - 1);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [DEC_W-1:0]   r_decim;
  logic [DEC_W-1:0]   w_decim_nxt;
  logic               r_prev_neg;
  logic               r_read_index;
  logic               w_read_index_nxt;
  logic [8:0]         r_write_address;
  logic [8:0]         w_write_address_nxt;
  logic               r_write_enable;
  logic               w_write_enable_nxt;
  logic [7:0]         r_write_sample;
  logic [7:0]         w_write_sample_nxt;

  logic               w_msb;
  logic [7:0]         w_conv;
  logic               w_crossing;
  logic               w_take;
  logic               w_unused_lsbs;

  assign w_msb         = new_sample_in[SAMPLE_W-1];
  assign w_conv        = new_sample_in[SAMPLE_W-1 -: 8] + 8'd128;
  assign w_crossing    = new_sample_ready & r_prev_neg & ~w_msb;
  assign w_take        = new_sample_ready & (r_decim == '0);
  assign w_unused_lsbs = ^new_sample_in[SAMPLE_W-9:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARMED:  if (w_crossing) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_take && (r_count == 8'hFF)) w_state_nxt = ST_WAIT;
      ST_WAIT:   if (wave_display_idle) w_state_nxt = ST_ARMED;
      default:   w_state_nxt = ST_ARMED;
    endcase
  end

  // Output / datapath next values; idle is only honoured in WAIT
  always_comb begin
    w_count_nxt         = r_count;
    w_decim_nxt         = r_decim;
    w_read_index_nxt    = r_read_index;
    w_write_address_nxt = r_write_address;
    w_write_enable_nxt  = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (w_crossing) begin
          w_write_enable_nxt  = 1'b1;
          w_write_address_nxt = {~r_read_index, 8'h00};
          w_count_nxt         = 8'd1;
          w_decim_nxt         = DEC_RELOAD;
        end
      end
      ST_ACTIVE: begin
        if (w_take) begin
          w_write_enable_nxt  = 1'b1;
          w_write_address_nxt = {~r_read_index, r_count};
          w_count_nxt         = r_count + 8'd1;
          w_decim_nxt         = DEC_RELOAD;
        end else if (new_sample_ready) begin
          w_decim_nxt = r_decim - 8'd1;
        end
      end
      ST_WAIT: begin
        if (wave_display_idle) begin
          w_read_index_nxt = ~r_read_index;
          w_count_nxt      = '0;
          w_decim_nxt      = '0;
        end
      end
      default: ;
    endcase
    w_write_sample_nxt = w_write_enable_nxt ? w_conv : r_write_sample;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count         <= '0;
      r_decim         <= '0;
      r_prev_neg      <= 1'b0;
      r_read_index    <= 1'b0;
      r_write_address <= '0;
      r_write_enable  <= 1'b0;
      r_write_sample  <= '0;
    end else begin
      r_count         <= w_count_nxt;
      r_decim         <= w_decim_nxt;
      r_read_index    <= w_read_index_nxt;
      r_write_address <= w_write_address_nxt;
      r_write_enable  <= w_write_enable_nxt;
      r_write_sample  <= w_write_sample_nxt;
      if (new_sample_ready) r_prev_neg <= w_msb;
    end
  end

  assign write_address = r_write_address;
  assign write_enable  = r_write_enable;
  assign write_sample  = r_write_sample;
  assign read_index    = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: DECIM=1 and DECIM=4 instances share stimulus and are
// scored against a per-instance reference model feeding expected-write queues.
module tb_wave_capture;

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int st;
    int cnt;
    int dec;
    bit pneg;
    bit ridx;
    int decim;
  } model_t;

  typedef struct {
    logic [15:0] s;
    logic        rdy;
    logic        idle;
    logic        we;
    logic [8:0]  a;
    logic [7:0]  d;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        ready;
  logic [15:0] sample_in;
  logic        idle_in;
  logic [8:0]  wa_o [2];
  logic        we_o [2];
  logic [7:0]  ws_o [2];
  logic        ri_o [2];

  int     checks;
  int     errors;
  int     strobes;
  int     strobe_at;
  int     wcnt [2];
  model_t m [2];
  wr_t    q0 [$];
  wr_t    q1 [$];
  vec_t   vecs [9];

  wave_capture #(.DECIM(1), .SAMPLE_W(16)) u_dut1 (
    .clk(clk), .reset(reset_n), .new_sample_ready(ready), .new_sample_in(sample_in),
    .wave_display_idle(idle_in), .write_address(wa_o[0]), .write_enable(we_o[0]),
    .write_sample(ws_o[0]), .read_index(ri_o[0])
  );

  wave_capture #(.DECIM(4), .SAMPLE_W(16)) u_dut4 (
    .clk(clk), .reset(reset_n), .new_sample_ready(ready), .new_sample_in(sample_in),
    .wave_display_idle(idle_in), .write_address(wa_o[1]), .write_enable(we_o[1]),
    .write_sample(ws_o[1]), .read_index(ri_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic wr_t pop_q(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic push_q(input int k, input wr_t w);
    if (k == 0) q0.push_back(w);
    else q1.push_back(w);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].st = 0; m[k].cnt = 0; m[k].dec = 0; m[k].pneg = 1'b0; m[k].ridx = 1'b0;
      wcnt[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int k, input logic [15:0] s, input logic rdy, input logic idle);
    wr_t  w;
    logic msb;
    msb = s[15];
    w.d = s[15:8] + 8'd128;
    w.a = '0;
    case (m[k].st)
      0: if (rdy && m[k].pneg && !msb) begin
        w.a = {~m[k].ridx, 8'h00};
        push_q(k, w);
        m[k].cnt = 1; m[k].dec = m[k].decim - 1; m[k].st = 1;
      end
      1: if (rdy) begin
        if (m[k].dec == 0) begin
          w.a = {~m[k].ridx, 8'(m[k].cnt)};
          push_q(k, w);
          m[k].dec = m[k].decim - 1;
          if (m[k].cnt == 255) begin m[k].cnt = 0; m[k].st = 2; end
          else m[k].cnt++;
        end else begin
          m[k].dec--;
        end
      end
      default: if (idle) begin
        m[k].ridx = ~m[k].ridx; m[k].cnt = 0; m[k].dec = 0; m[k].st = 0;
      end
    endcase
    if (rdy) m[k].pneg = msb;
  endtask

  task automatic check_out();
    wr_t w;
    for (int k = 0; k < 2; k++) begin
      if (we_o[k]) begin
        wcnt[k]++;
        if (k == 1 && wcnt[1] == 256) strobe_at = strobes;
        if (qsize(k) == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write dut%0d addr=%0h data=%0h", k, wa_o[k], ws_o[k]);
        end else begin
          w = pop_q(k);
          chk($sformatf("wr_addr dut%0d", k), 32'(wa_o[k]), 32'(w.a));
          chk($sformatf("wr_data dut%0d", k), 32'(ws_o[k]), 32'(w.d));
        end
      end else if (qsize(k) != 0) begin
        w = pop_q(k);
        checks++; errors++;
        $display("FAIL missing_write dut%0d actual=none expected addr=%0h data=%0h", k, w.a, w.d);
      end
      chk($sformatf("read_index dut%0d", k), 32'(ri_o[k]), 32'(m[k].ridx));
    end
  endtask

  task automatic drive(input logic [15:0] s, input logic rdy, input logic idle);
    @(negedge clk);
    sample_in = s;
    ready     = rdy;
    idle_in   = idle;
    if (rdy) strobes++;
    model_step(0, s, rdy, idle);
    model_step(1, s, rdy, idle);
    @(posedge clk);
    #1;
    check_out();
    ready   = 1'b0;
    idle_in = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_we"},   32'(we_o[k]), 32'd0);
      chk({tag, "_addr"}, 32'(wa_o[k]), 32'd0);
      chk({tag, "_data"}, 32'(ws_o[k]), 32'd0);
      chk({tag, "_ridx"}, 32'(ri_o[k]), 32'd0);
    end
  endtask

  initial begin
    int i;
    checks = 0; errors = 0; strobes = 0; strobe_at = 0;
    m[0].decim = 1;
    m[1].decim = 4;
    model_reset();
    reset_n = 1'b0; ready = 1'b0; idle_in = 1'b0; sample_in = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // {sample, ready, idle, dut1 expected we/addr/data}
    vecs = '{
      '{16'h0100, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00},
      '{16'h0200, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00},
      '{16'hFF00, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00},
      '{16'h0300, 1'b1, 1'b0, 1'b1, 9'h100, 8'h83},
      '{16'h8000, 1'b1, 1'b0, 1'b1, 9'h101, 8'h00},
      '{16'h0000, 1'b1, 1'b0, 1'b1, 9'h102, 8'h80},
      '{16'h7FFF, 1'b1, 1'b0, 1'b1, 9'h103, 8'hFF},
      '{16'h1234, 1'b0, 1'b1, 1'b0, 9'h000, 8'h00},
      '{16'hFFFF, 1'b1, 1'b0, 1'b1, 9'h104, 8'h7F}
    };
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].s, vecs[v].rdy, vecs[v].idle);
      chk($sformatf("vec%0d_we", v), 32'(we_o[0]), 32'(vecs[v].we));
      if (vecs[v].we) begin
        chk($sformatf("vec%0d_addr", v), 32'(wa_o[0]), 32'(vecs[v].a));
        chk($sformatf("vec%0d_data", v), 32'(ws_o[0]), 32'(vecs[v].d));
      end
    end

    // Finish the DECIM=1 buffer, then extra strobes must not write
    for (int n = 0; n < 251; n++) drive(16'($urandom), 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) drive(16'($urandom), 1'b1, 1'b0);
    chk("dut1_writes_first", 32'(wcnt[0]), 32'd256);
    chk("dut1_ridx_before_idle", 32'(ri_o[0]), 32'd0);

    for (int n = 0; n < 3; n++) drive(16'h0000, 1'b0, 1'b1);
    chk("dut1_ridx_toggled_once", 32'(ri_o[0]), 32'd1);

    // Second capture lands in the lower half
    drive(16'hFF00, 1'b1, 1'b0);
    drive(16'h0300, 1'b1, 1'b0);
    chk("cap2_first_addr", 32'(wa_o[0]), 32'h000);
    chk("cap2_first_data", 32'(ws_o[0]), 32'h83);
    for (int n = 0; n < 255; n++) drive(16'h0100, 1'b1, 1'b0);
    chk("cap2_last_we", 32'(we_o[0]), 32'd1);
    chk("cap2_last_addr", 32'(wa_o[0]), 32'h0FF);
    chk("dut1_writes_second", 32'(wcnt[0]), 32'd512);

    // Let DECIM=4 complete its buffer
    i = 0;
    while (m[1].st != 2 && i < 2000) begin
      drive(16'h0100, 1'b1, 1'b0);
      i++;
    end
    if (i >= 2000) begin
      checks++; errors++;
      $display("FAIL dut4_wait_timeout actual=%0d expected=<2000", i);
    end
    chk("dut4_writes", 32'(wcnt[1]), 32'd256);
    chk("dut4_strobe_of_256th", 32'(strobe_at), 32'd1024);

    // Strobe and idle together in WAIT: toggle, crossing not evaluated
    drive(16'hFF00, 1'b1, 1'b0);
    drive(16'h0300, 1'b1, 1'b1);
    chk("simul_no_write1", 32'(we_o[0]), 32'd0);
    chk("simul_no_write4", 32'(we_o[1]), 32'd0);
    chk("simul_ridx1", 32'(ri_o[0]), 32'd0);
    chk("simul_ridx4", 32'(ri_o[1]), 32'd1);
    drive(16'h0300, 1'b1, 1'b0);
    chk("no_cross_after_simul", 32'(we_o[0]), 32'd0);

    // Reset partway through a capture
    drive(16'hFF00, 1'b1, 1'b0);
    drive(16'h0300, 1'b1, 1'b0);
    i = 0;
    while (m[0].cnt != 100 && i < 300) begin
      drive(16'h0100, 1'b1, 1'b0);
      i++;
    end
    if (i >= 300) begin
      checks++; errors++;
      $display("FAIL count100_timeout actual=%0d expected=<300", i);
    end
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    drive(16'h0300, 1'b1, 1'b0);
    chk("post_reset_no_cross", 32'(we_o[0]), 32'd0);
    drive(16'hFF00, 1'b1, 1'b0);
    drive(16'h0300, 1'b1, 1'b0);
    chk("post_reset_we", 32'(we_o[0]), 32'd1);
    chk("post_reset_addr", 32'(wa_o[0]), 32'h100);
    chk("post_reset_data", 32'(ws_o[0]), 32'h83);
    for (int n = 0; n < 8; n++) drive(16'($urandom), 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Producer side of the sample RAM that the waveform display reads.
- Watches the audio sample stream and arms on a positive-going zero crossing.
- Writes 256 offset-binary 8-bit samples into the half of the 512-entry RAM that is not being displayed.
- Once the display reports idle, flips read_index so the display picks up the new half.

Parameters:
DECIM, 1, capture one of every DECIM accepted samples once ACTIVE (legal range 1..256)
SAMPLE_W, 16, width of signed input sample; top 8 bits are captured

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
new_sample_ready  input  1  one-cycle strobe; new_sample_in valid this cycle
new_sample_in  input  SAMPLE_W  signed two's-complement audio sample
wave_display_idle  input  1  high while display is outside the active region (frame blanking)
write_address  output  9  {~read_index, count[7:0]}; RAM write address
write_enable  output  1  one-cycle RAM write strobe
write_sample  output  8  new_sample_in[SAMPLE_W-1 -: 8] + 8'd128, modulo 256
read_index  output  1  RAM half currently owned by the display

Behaviour:
- Reset (reset low, asynchronous):
  - state=ARMED, count=0, decim_cnt=0, prev_neg=0.
  - read_index=0, write_enable=0, write_address=0, write_sample=0.
- All outputs are registered. A qualifying new_sample_ready in cycle N gives write_enable=1 in cycle N+1, with matching address and data. Each strobe produces exactly one write cycle.
- prev_neg is updated to new_sample_in[MSB] on every new_sample_ready, in all states.
- ARMED:
  - A crossing is new_sample_ready=1 with prev_neg=1 and new_sample_in[MSB]=0.
  - On a crossing: write the sample at count 0, set count=1, decim_cnt=DECIM-1, go to ACTIVE.
  - All other samples: no write.
- ACTIVE, on each new_sample_ready:
  - If decim_cnt==0: write at {~read_index,count}, reload decim_cnt=DECIM-1, increment count.
  - Otherwise: decrement decim_cnt, no write.
  - After the write at count 255: count wraps to 0 and the state goes to WAIT. The 256 writes cover addresses {~read_index,8'h00..8'hFF} exactly.
- WAIT:
  - new_sample_ready produces no writes.
  - When wave_display_idle=1: toggle read_index, count=0, decim_cnt=0, go to ARMED. read_index changes in the same cycle as the state change.
  - At most one toggle per capture. The next buffer cannot toggle until 256 fresh writes have completed.
- Simultaneous events:
  - wave_display_idle in ARMED or ACTIVE is ignored.
  - In WAIT, if new_sample_ready and wave_display_idle arrive together: toggle and move to ARMED. prev_neg updates, but a crossing is not evaluated that cycle.
- write_address[8] is always ~read_index at the time of the write, so writes never touch the half being displayed.
- Reset mid-capture abandons the partial buffer and returns to ARMED with read_index=0. A partial buffer is never exposed.
- The write_sample conversion is pure bit slice plus add, with no saturation:
  - 16'h8000 -> 8'h00
  - 16'h0000 -> 8'h80
  - 16'h7FFF -> 8'hFF

Test Plan:
- Reset then samples 16'h0100,16'h0200 (no negative first) -> no write_enable; state stays ARMED.
- DECIM=1, samples 16'hFF00 then 16'h0300 -> one cycle later write_enable=1, write_address=9'h100, write_sample=8'h83.
- DECIM=1, crossing followed by 255 further strobes -> exactly 256 writes to 9'h100..9'h1FF, in order. Extra strobes before idle produce no writes; read_index stays 0.
- In WAIT assert wave_display_idle for 3 cycles -> read_index 0->1 once. The next capture writes 9'h000..9'h0FF, and the following WAIT+idle returns read_index to 0.
- DECIM=4 -> writes on the crossing sample, then every 4th strobe. Count reaches 255 after 1+255*4 strobes.
- Reset pulse at count 100 -> outputs cleared immediately (async). Next capture starts at address 9'h100 after a fresh crossing.
